hilo_regfile: RTL and testbench
===============================

Name: hilo_regfile

Overview:
- Holds the architectural HI/LO register pair and closes the loop with the EX-stage ALU.
- Accepts the ALU's 64-bit HI/LO write requests (w_hilo, write_hi, write_lo) and carries them through MEM and WB staging registers.
- Commits a request at WB and returns the youngest valid HI/LO value to the ALU's HI/LO inputs.
- Handles pipeline stall and flush, and forwards from in-flight stages so that MFHI/MFLO/MTHI/MTLO back-to-back sequences read correct values.

Parameters:
LENGTH, 32, width of HI and of LO (matches the codebase-wide `LENGTH)
RST_VAL, 0, reset value of the architectural HI and LO

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
w_hilo  input  1  EX-stage HI/LO write request from the ALU
write_hi  input  LENGTH  HI value of the request
write_lo  input  LENGTH  LO value of the request
hilo_rd  input  1  EX-stage instruction reads HI/LO (MFHI/MFLO/MTHI/MTLO)
stall  input  1  freeze all staging and commit this cycle
flush  input  1  kill EX and MEM requests (exception/redirect)
hi  output  LENGTH  forwarded HI, drives the ALU HI input
lo  output  LENGTH  forwarded LO, drives the ALU LO input
hazard  output  1  read-after-write stall request to the pipeline controller
commit  output  1  pulse: WB entry written to architectural HI/LO this edge

Behaviour:
- State:
  - s1 (MEM) = {v1, hi1, lo1}
  - s2 (WB) = {v2, hi2, lo2}
  - arch = {arch_hi, arch_lo}
- Reset (async, rst_n=0):
  - v1 = v2 = 0; hi1/lo1/hi2/lo2 = 0; arch_hi = arch_lo = RST_VAL.
  - Registered outputs clear immediately; hi/lo = RST_VAL.
  - Reset mid-flight discards all pending requests.
- Each rising edge, priority flush > stall > normal.
  - Normal (!stall, !flush):
    - s1 <= {w_hilo, write_hi, write_lo}
    - s2 <= s1
    - if v2: arch <= {hi2, lo2}
  - Flush (regardless of stall):
    - v1 <= 0; v2 <= 0 only for the entry moving from s1.
    - The entry already in s2 still commits: it is past the exception point.
    - The request present on w_hilo that cycle is dropped.
  - Stall (!flush): s1, s2 and arch all hold; commit = 0.
- commit is a registered pulse, 1 cycle after the edge at which the WB entry was committed.
- Latency: a request accepted at edge N reaches s2 at N+1 and is architectural after edge N+2 (2 un-stalled edges).
- Writes are always full 64-bit; the ALU supplies the unchanged half for MTHI/MTLO.
- Read path (combinational):
  - {hi, lo} = v1 ? {hi1, lo1} : v2 ? {hi2, lo2} : arch (youngest wins).
  - Never forwards from the current-cycle w_hilo input; this avoids an ALU combinational loop.
- hazard = 0 when forwarding is compiled in.
- Boundaries:
  - Back-to-back requests pipeline at 1/cycle with no bubbles.
  - stall and flush together behave as flush.
  - w_hilo with flush is dropped.
  - Identical consecutive values still produce one commit pulse each.

Optional Feature:
Macro HILO_FWD_EN.
- Defined: read path and hazard behave as in Behaviour (full forwarding, hazard tied 0).
- Undefined:
  - {hi, lo} = arch only.
  - hazard = hilo_rd & (v1 | v2), combinational.
  - The controller stalls EX while s1/s2 drain; hazard falls once both are committed.

Decomposition:
- Shared package holds:
  - LENGTH
  - a hilo_entry_t typedef {valid, hi, lo}
  - RST_VAL default
  - the HI/LO-related ALU control encodings (MULT, MULTU, DIVU, MTHI, MTLO, MFHI, MFLO), so decode of hilo_rd uses the same constants.
- One sub-module is natural: hilo_stage, a single valid/data staging register with stall/kill inputs, instantiated twice.

Test Plan:
- Reset: assert rst_n=0 mid-stream with v1=v2=1 -> hi=lo=0, hazard=0, commit=0 immediately; no commit after release.
- Throughput: w_hilo=1 on 3 consecutive cycles with (HI,LO) = (1,2), (3,4), (5,6) -> commit pulses on 3 consecutive cycles; final arch = (5,6).
- Forwarding (HILO_FWD_EN):
  - MTHI writes (0xDEADBEEF, LO=7), next cycle hilo_rd=1 -> hi=0xDEADBEEF, lo=7 while v1=1.
  - One cycle later -> same values from s2.
- Flush:
  - Request (0xA,0xB) in s2 and (0xC,0xD) in s1, flush=1 -> arch becomes (0xA,0xB).
  - (0xC,0xD) never commits; hi/lo = (0xA,0xB).
- Stall: request (0x11,0x22) in s1, stall=1 for 4 cycles -> s1 held, no commit; commit occurs 2 un-stalled edges after release.
- No HILO_FWD_EN: request then hilo_rd=1 next cycle -> hazard=1 for 2 cycles; hi/lo show the old arch until commit, then the new value with hazard=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared HI/LO definitions: default widths, the staging entry type and the
// HI/LO-related ALU control encodings used to decode hilo_rd.
package hilo_pkg;

   localparam int DEF_LENGTH = 32;
   localparam logic [DEF_LENGTH-1:0] DEF_RST_VAL = '0;

   typedef struct packed {
      logic                  valid;
      logic [DEF_LENGTH-1:0] hi;
      logic [DEF_LENGTH-1:0] lo;
   } hilo_entry_t;

   typedef enum logic [4:0] {
      ALU_NOP   = 5'h00,
      ALU_ADD   = 5'h01,
      ALU_SUB   = 5'h02,
      ALU_MULT  = 5'h10,
      ALU_MULTU = 5'h11,
      ALU_DIVU  = 5'h12,
      ALU_MTHI  = 5'h13,
      ALU_MTLO  = 5'h14,
      ALU_MFHI  = 5'h15,
      ALU_MFLO  = 5'h16
   } alu_op_t;

   // Instructions whose EX result depends on the current HI/LO value.
   function automatic logic reads_hilo(alu_op_t op);
      return op inside {ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO};
   endfunction

   function automatic logic writes_hilo(alu_op_t op);
      return op inside {ALU_MULT, ALU_MULTU, ALU_DIVU, ALU_MTHI, ALU_MTLO};
   endfunction

endpackage

// File: rtl/hilo_stage.sv
// One valid/data staging register for a HI/LO write request, with hold (stall)
// and kill (flush) controls; kill wins over stall.
module hilo_stage
   import hilo_pkg::*;
#(
   parameter int WIDTH = DEF_LENGTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             kill,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_hi,
   input  logic [WIDTH-1:0] d_lo,
   output logic             valid,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // NOTE: a killed entry still moves data along; only its valid bit is cleared,
   // so downstream never acts on it and the payload needs no special handling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else if (kill) begin
         valid <= 1'b0;
         hi    <= d_hi;
         lo    <= d_lo;
      end else if (!stall) begin
         valid <= d_valid;
         hi    <= d_hi;
         lo    <= d_lo;
      end
   end

endmodule

// File: rtl/hilo_regfile.sv
// Architectural HI/LO pair with MEM/WB staging of ALU write requests.
// Define HILO_FWD_EN for forwarding from in-flight stages; otherwise hazard stalls EX.
module hilo_regfile
   import hilo_pkg::*;
#(
   parameter int              LENGTH  = DEF_LENGTH,
   parameter logic [LENGTH-1:0] RST_VAL = LENGTH'(DEF_RST_VAL)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_hilo,
   input  logic [LENGTH-1:0] write_hi,
   input  logic [LENGTH-1:0] write_lo,
   input  logic              hilo_rd,
   input  logic              stall,
   input  logic              flush,
   output logic [LENGTH-1:0] hi,
   output logic [LENGTH-1:0] lo,
   output logic              hazard,
   output logic              commit
);

   logic              v1, v2;
   logic [LENGTH-1:0] hi1, lo1, hi2, lo2;
   logic [LENGTH-1:0] arch_hi, arch_lo;
   logic              commit_now;

   hilo_stage #(.WIDTH(LENGTH)) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .stall   (stall),
      .kill    (flush),
      .d_valid (w_hilo),
      .d_hi    (write_hi),
      .d_lo    (write_lo),
      .valid   (v1),
      .hi      (hi1),
      .lo      (lo1)
   );

   hilo_stage #(.WIDTH(LENGTH)) u_wb (
      .clk     (clk),
      .rst_n   (rst_n),
      .stall   (stall),
      .kill    (flush),
      .d_valid (v1),
      .d_hi    (hi1),
      .d_lo    (lo1),
      .valid   (v2),
      .hi      (hi2),
      .lo      (lo2)
   );

   // The WB entry is past the exception point, so a flush still lets it commit.
   assign commit_now = v2 & (flush | ~stall);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arch_hi <= RST_VAL;
         arch_lo <= RST_VAL;
         commit  <= 1'b0;
      end else begin
         commit <= commit_now;
         if (commit_now) begin
            arch_hi <= hi2;
            arch_lo <= lo2;
         end
      end
   end

`ifdef HILO_FWD_EN
   logic unused_rd;
   assign unused_rd = hilo_rd;

   // Youngest valid value wins; the current w_hilo input is deliberately not
   // forwarded, which would close a combinational loop through the ALU.
   always_comb begin
      hi = arch_hi;
      lo = arch_lo;
      if (v1) begin
         hi = hi1;
         lo = lo1;
      end else if (v2) begin
         hi = hi2;
         lo = lo2;
      end
   end

   assign hazard = 1'b0;
`else
   assign hi     = arch_hi;
   assign lo     = arch_lo;
   assign hazard = hilo_rd & (v1 | v2);
`endif

endmodule

// File: tb/tb_hilo_regfile.sv
// Self-checking bench for hilo_regfile: directed scenarios plus random traffic
// compared against a queue-based model of the in-flight HI/LO requests.
module tb_hilo_regfile;
   import hilo_pkg::*;

   localparam int L = DEF_LENGTH;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         w_hilo;
   logic [L-1:0] write_hi;
   logic [L-1:0] write_lo;
   logic         hilo_rd;
   logic         stall;
   logic         flush;
   logic [L-1:0] hi;
   logic [L-1:0] lo;
   logic         hazard;
   logic         commit;

   always #5 clk = ~clk;

   hilo_regfile #(.LENGTH(L), .RST_VAL(DEF_RST_VAL)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_hilo   (w_hilo),
      .write_hi (write_hi),
      .write_lo (write_lo),
      .hilo_rd  (hilo_rd),
      .stall    (stall),
      .flush    (flush),
      .hi       (hi),
      .lo       (lo),
      .hazard   (hazard),
      .commit   (commit)
   );

   int errors = 0;
   int checks = 0;

   // Model: pend[0] is the youngest in-flight request, pend[$] the oldest.
   hilo_entry_t  pend[$];
   logic [L-1:0] m_hi, m_lo;
   logic         m_commit;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      pend.push_back('{valid: 1'b0, hi: '0, lo: '0});
      pend.push_back('{valid: 1'b0, hi: '0, lo: '0});
      m_hi     = DEF_RST_VAL;
      m_lo     = DEF_RST_VAL;
      m_commit = 1'b0;
   endtask

   // Request travels two un-stalled edges to become architectural.
   task automatic model_edge();
      hilo_entry_t oldest;
      if (flush || !stall) begin
         oldest   = pend.pop_back();
         m_commit = oldest.valid;
         if (oldest.valid) begin
            m_hi = oldest.hi;
            m_lo = oldest.lo;
         end
         if (flush)
            foreach (pend[i]) pend[i].valid = 1'b0;
         pend.push_front('{valid: w_hilo && !flush, hi: write_hi, lo: write_lo});
      end else begin
         m_commit = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [L-1:0] eh, el;
      logic         busy;
      eh   = m_hi;
      el   = m_lo;
      busy = 1'b0;
      foreach (pend[i]) busy |= pend[i].valid;
`ifdef HILO_FWD_EN
      for (int i = pend.size() - 1; i >= 0; i--) begin
         if (pend[i].valid) begin
            eh = pend[i].hi;
            el = pend[i].lo;
         end
      end
      check({tag, "_hazard"}, 64'(hazard), 64'(1'b0));
`else
      check({tag, "_hazard"}, 64'(hazard), 64'(hilo_rd & busy));
`endif
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      check({tag, "_commit"}, 64'(commit), 64'(m_commit));
   endtask

   task automatic step(input logic w, input logic [L-1:0] h, input logic [L-1:0] l,
                       input logic rd, input logic st, input logic fl, input string tag);
      w_hilo   = w;
      write_hi = h;
      write_lo = l;
      hilo_rd  = rd;
      stall    = st;
      flush    = fl;
      #1 check_outputs(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      alu_op_t op;
      rst_n = 1'b0;
      w_hilo = 1'b0; write_hi = '0; write_lo = '0;
      hilo_rd = 1'b0; stall = 1'b0; flush = 1'b0;
      model_reset();
      #12;
      check_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Throughput: three back-to-back requests commit on consecutive cycles.
      step(1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, "thru0");
      step(1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, "thru1");
      step(1'b1, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0, "thru2");
      idle(3, "thru_drain");
      check("thru_final_hi", 64'(hi), 64'd5);
      check("thru_final_lo", 64'(lo), 64'd6);

      // Read right behind an MTHI: forwarded, or hazard until it commits.
      step(1'b1, 32'hDEADBEEF, 32'd7, 1'b1, 1'b0, 1'b0, "mthi");
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "fwd_s1");
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "fwd_s2");
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "fwd_arch");
      check("fwd_final_hi", 64'(hi), 64'hDEADBEEF);

      // Flush: the WB entry commits, the MEM entry and the new request die.
      step(1'b1, 32'hA, 32'hB, 1'b0, 1'b0, 1'b0, "fl_a");
      step(1'b1, 32'hC, 32'hD, 1'b0, 1'b0, 1'b0, "fl_c");
      step(1'b1, 32'hE, 32'hF, 1'b0, 1'b1, 1'b1, "fl_go");
      idle(3, "fl_drain");
      check("flush_final_hi", 64'(hi), 64'hA);
      check("flush_final_lo", 64'(lo), 64'hB);

      // Stall holds everything for four cycles.
      step(1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, "st_req");
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, "st_hold");
      idle(3, "st_release");
      check("stall_final_hi", 64'(hi), 64'h11);

      // Identical consecutive values each get their own commit pulse.
      step(1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, "same0");
      step(1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, "same1");
      idle(2, "same_drain");

      // Reset with both stages full discards them immediately.
      step(1'b1, 32'h55, 32'h66, 1'b1, 1'b0, 1'b0, "pre_rst0");
      step(1'b1, 32'h77, 32'h88, 1'b1, 1'b0, 1'b0, "pre_rst1");
      w_hilo = 1'b0;
      rst_n  = 1'b0;
      #1;
      model_reset();
      check_outputs("rst_mid");
      check("rst_mid_hi0", 64'(hi), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3, "post_rst");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         op = alu_op_t'($urandom_range(0, 9));
         step(($urandom_range(0, 1) == 1) || writes_hilo(op), L'($urandom), L'($urandom),
              reads_hilo(op), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, "rand");
      end
      idle(3, "rand_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
